// File: rtl/fifo_pkg.sv
// Shared types and constants for the parameterised FIFO controller.
// Optional build macro used by param_fifo_ctrl: FIFO_STATS_EN (adds max_level).
package fifo_pkg;

  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH  = 16;

  // Bits needed to hold values 0..n-1; never returns less than 1.
  function automatic int width_for(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  typedef struct packed {
    logic full;
    logic empty;
    logic almost_full;
    logic almost_empty;
    logic over_flow;
    logic under_flow;
  } fifo_status_t;

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port RAM: one synchronous write port, one registered read port.
// The array itself is never reset; only the read data register is.
module fifo_dpram
  import fifo_pkg::*;
#(
  parameter  int DATA_W = DEF_DATA_W,
  parameter  int DEPTH  = DEF_DEPTH,
  localparam int ADDR_W = width_for(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port; holds its value when no read is requested.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/param_fifo_ctrl.sv
// Parameterised synchronous FIFO: pointer/count control around fifo_dpram.
// Flags are registered from the next-state count so they move with the transfer.
// Build macro FIFO_STATS_EN adds the max_level high-water mark output.
module param_fifo_ctrl
  import fifo_pkg::*;
#(
  parameter  int DATA_W    = DEF_DATA_W,
  parameter  int DEPTH     = DEF_DEPTH,
  parameter  int AF_THRESH = DEPTH - 2,
  parameter  int AE_THRESH = 2,
  localparam int ADDR_W    = width_for(DEPTH),
  localparam int CNT_W     = width_for(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] din,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              rd_valid,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [CNT_W-1:0]  count,
  output logic              over_flow,
  output logic              under_flow,
  output logic              err_sticky
`ifdef FIFO_STATS_EN
  ,
  output logic [CNT_W-1:0]  max_level
`endif
);

  if (AF_THRESH < 0 || AF_THRESH > DEPTH) begin : g_bad_af
    $error("param_fifo_ctrl: AF_THRESH must lie in 0..DEPTH");
  end
  if (AE_THRESH < 0 || AE_THRESH >= DEPTH) begin : g_bad_ae
    $error("param_fifo_ctrl: AE_THRESH must lie in 0..DEPTH-1");
  end

  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0]  count_q, count_nxt;
  fifo_status_t      stat_q, stat_nxt;
  logic              rd_valid_q, err_q;
  logic              wr_acc, rd_acc, wr_rej, rd_rej;

  // Accept/reject decode; flush swallows both requests without error pulses.
  always_comb begin
    wr_acc = wr_en && !stat_q.full  && !flush;
    rd_acc = rd_en && !stat_q.empty && !flush;
    wr_rej = wr_en &&  stat_q.full  && !flush;
    rd_rej = rd_en &&  stat_q.empty && !flush;
  end

  // Next occupancy and the flags derived from it.
  always_comb begin
    if (flush) count_nxt = '0;
    else       count_nxt = count_q + CNT_W'(wr_acc) - CNT_W'(rd_acc);
    stat_nxt.full         = (count_nxt == CNT_W'(DEPTH));
    stat_nxt.empty        = (count_nxt == '0);
    stat_nxt.almost_full  = (count_nxt >= CNT_W'(AF_THRESH));
    stat_nxt.almost_empty = (count_nxt <= CNT_W'(AE_THRESH));
    stat_nxt.over_flow    = wr_rej;
    stat_nxt.under_flow   = rd_rej;
  end

  // Pointers, count, flags and error state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      stat_q     <= '{full: 1'b0, empty: 1'b1, almost_full: 1'b0,
                      almost_empty: 1'b1, over_flow: 1'b0, under_flow: 1'b0};
      rd_valid_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      count_q    <= count_nxt;
      stat_q     <= stat_nxt;
      rd_valid_q <= rd_acc;
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        err_q  <= 1'b0;
      end else begin
        if (wr_acc) wr_ptr <= (wr_ptr == ADDR_W'(DEPTH - 1)) ? '0 : wr_ptr + ADDR_W'(1);
        if (rd_acc) rd_ptr <= (rd_ptr == ADDR_W'(DEPTH - 1)) ? '0 : rd_ptr + ADDR_W'(1);
        if (wr_rej || rd_rej) err_q <= 1'b1;
      end
    end
  end

`ifdef FIFO_STATS_EN
  logic [CNT_W-1:0] max_q;

  // High-water mark of occupancy since the last reset or flush.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                 max_q <= '0;
    else if (flush)             max_q <= '0;
    else if (count_nxt > max_q) max_q <= count_nxt;
  end

  assign max_level = max_q;
`endif

  // A read address never collides with an accepted write: rd_ptr == wr_ptr only
  // when empty (read rejected) or full (write rejected).
  fifo_dpram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (dout)
  );

  assign count        = count_q;
  assign full         = stat_q.full;
  assign empty        = stat_q.empty;
  assign almost_full  = stat_q.almost_full;
  assign almost_empty = stat_q.almost_empty;
  assign over_flow    = stat_q.over_flow;
  assign under_flow   = stat_q.under_flow;
  assign rd_valid     = rd_valid_q;
  assign err_sticky   = err_q;

endmodule

// File: tb/tb_param_fifo_ctrl.sv
// Bench for param_fifo_ctrl: queue-based reference model, per-cycle compare,
// directed scenarios with literal expectations, then randomized traffic.
module tb_param_fifo_ctrl;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int AF     = 14;
  localparam int AE     = 2;
  localparam int CNT_W  = 5;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              flush = 1'b0;
  logic              wr_en = 1'b0;
  logic [DATA_W-1:0] din = '0;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] dout;
  logic              rd_valid, full, empty, almost_full, almost_empty;
  logic [CNT_W-1:0]  count;
  logic              over_flow, under_flow, err_sticky;
`ifdef FIFO_STATS_EN
  logic [CNT_W-1:0]  max_level;
`endif

  int checks = 0;
  int errors = 0;
  bit cmp_en = 1'b0;

  param_fifo_ctrl #(
    .DATA_W (DATA_W), .DEPTH (DEPTH), .AF_THRESH (AF), .AE_THRESH (AE)
  ) dut (
    .clk (clk), .rst_n (rst_n), .flush (flush), .wr_en (wr_en), .din (din),
    .rd_en (rd_en), .dout (dout), .rd_valid (rd_valid), .full (full),
    .empty (empty), .almost_full (almost_full), .almost_empty (almost_empty),
    .count (count), .over_flow (over_flow), .under_flow (under_flow),
    .err_sticky (err_sticky)
`ifdef FIFO_STATS_EN
    , .max_level (max_level)
`endif
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  // Reference model: contents as a queue, outputs from the transfer rules.
  logic [DATA_W-1:0] q[$];
  logic [DATA_W-1:0] m_dout = '0;
  bit m_rv = 0, m_ovf = 0, m_udf = 0, m_err = 0;
  int m_max = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_dout = '0; m_rv = 0; m_ovf = 0; m_udf = 0; m_err = 0; m_max = 0;
    end else begin
      bit can_w, can_r;
      m_rv = 0; m_ovf = 0; m_udf = 0;
      if (flush) begin
        q.delete();
        m_err = 0;
        m_max = 0;
      end else begin
        can_w = q.size() < DEPTH;
        can_r = q.size() > 0;
        if (rd_en) begin
          if (can_r) begin m_dout = q.pop_front(); m_rv = 1; end
          else begin m_udf = 1; m_err = 1; end
        end
        if (wr_en) begin
          if (can_w) q.push_back(din);
          else begin m_ovf = 1; m_err = 1; end
        end
        if (q.size() > m_max) m_max = q.size();
      end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("m_dout", 32'(dout), 32'(m_dout));
      chk("m_rd_valid", 32'(rd_valid), 32'(m_rv));
      chk("m_count", 32'(count), 32'(q.size()));
      chk("m_full", 32'(full), 32'(q.size() == DEPTH));
      chk("m_empty", 32'(empty), 32'(q.size() == 0));
      chk("m_almost_full", 32'(almost_full), 32'(q.size() >= AF));
      chk("m_almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
      chk("m_over_flow", 32'(over_flow), 32'(m_ovf));
      chk("m_under_flow", 32'(under_flow), 32'(m_udf));
      chk("m_err_sticky", 32'(err_sticky), 32'(m_err));
`ifdef FIFO_STATS_EN
      chk("m_max_level", 32'(max_level), 32'(m_max));
`endif
    end
  end

  // Drive one cycle of inputs, return at the following falling edge.
  task automatic cyc(input bit w, input logic [DATA_W-1:0] d, input bit r, input bit f);
    wr_en = w; din = d; rd_en = r; flush = f;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0; flush = 1'b0;
  endtask

  initial begin
    int bias;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    cmp_en = 1'b1;

    chk("rst_count", 32'(count), 0);
    chk("rst_empty", 32'(empty), 1);
    chk("rst_almost_empty", 32'(almost_empty), 1);
    chk("rst_full", 32'(full), 0);
    chk("rst_dout", 32'(dout), 0);

    // Fill with 0x00..0x0F.
    for (int i = 0; i < 16; i++) cyc(1, 8'(i), 0, 0);
    chk("fill_full", 32'(full), 1);
    chk("fill_count", 32'(count), 16);
    chk("fill_almost_full", 32'(almost_full), 1);
`ifdef FIFO_STATS_EN
    chk("fill_max_level", 32'(max_level), 16);
`endif

    // Overflow while full.
    cyc(1, 8'hAA, 0, 0);
    chk("ovf_pulse", 32'(over_flow), 1);
    chk("ovf_err", 32'(err_sticky), 1);
    chk("ovf_count", 32'(count), 16);
    cyc(0, 0, 0, 0);
    chk("ovf_pulse_end", 32'(over_flow), 0);

    // Simultaneous read/write while full.
    cyc(1, 8'h55, 1, 0);
    chk("fullrw_dout", 32'(dout), 32'h00);
    chk("fullrw_valid", 32'(rd_valid), 1);
    chk("fullrw_ovf", 32'(over_flow), 1);
    chk("fullrw_count", 32'(count), 15);

    // Drain the remaining 0x01..0x0F.
    for (int i = 1; i < 16; i++) begin
      cyc(0, 0, 1, 0);
      chk("drain_dout", 32'(dout), 32'(i));
      chk("drain_valid", 32'(rd_valid), 1);
    end
    chk("drain_empty", 32'(empty), 1);

    // Underflow from empty.
    cyc(0, 0, 1, 0);
    chk("udf_pulse", 32'(under_flow), 1);
    chk("udf_valid", 32'(rd_valid), 0);
    chk("udf_dout_hold", 32'(dout), 32'h0F);
    cyc(1, 8'h33, 1, 0);
    chk("udf_rw_count", 32'(count), 1);
    chk("udf_rw_pulse", 32'(under_flow), 1);

    // Flush at count 7 with a concurrent write.
    for (int i = 0; i < 6; i++) cyc(1, 8'(8'h40 + i), 0, 0);
    chk("pre_flush_count", 32'(count), 7);
    cyc(1, 8'hEE, 0, 1);
    chk("flush_count", 32'(count), 0);
    chk("flush_empty", 32'(empty), 1);
    chk("flush_ovf", 32'(over_flow), 0);
    chk("flush_err", 32'(err_sticky), 0);
    chk("flush_dout_hold", 32'(dout), 32'h0F);
`ifdef FIFO_STATS_EN
    chk("flush_max_level", 32'(max_level), 0);
`endif

    // Thresholds.
    for (int i = 0; i < 13; i++) cyc(1, 8'(8'h80 + i), 0, 0);
    chk("af_at_13", 32'(almost_full), 0);
    cyc(1, 8'h8D, 0, 0);
    chk("af_at_14", 32'(almost_full), 1);
    for (int i = 0; i < 11; i++) cyc(0, 0, 1, 0);
    chk("ae_at_3", 32'(almost_empty), 0);
    cyc(0, 0, 1, 0);
    chk("ae_at_2", 32'(almost_empty), 1);
    chk("ae_count", 32'(count), 2);

    // Interleaved traffic drives both pointers through the wrap.
    for (int i = 0; i < 20; i++) cyc(1, 8'(8'hC0 + i), 1, 0);
    chk("wrap_count", 32'(count), 2);
    chk("wrap_dout", 32'(dout), 32'hD1);

    // Randomized traffic with a slowly changing fill bias.
    bias = 50;
    for (int i = 0; i < 3000; i++) begin
      if (i % 150 == 0) bias = $urandom_range(15, 85);
      cyc($urandom_range(99) < bias, 8'($urandom), $urandom_range(99) >= bias,
          $urandom_range(199) == 0);
    end

    // Asynchronous reset in the middle of a write burst.
    for (int i = 0; i < 5; i++) cyc(1, 8'(8'h20 + i), 0, 0);
    wr_en = 1'b1; din = 8'h99;
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", 32'(count), 0);
    chk("arst_empty", 32'(empty), 1);
    chk("arst_full", 32'(full), 0);
    chk("arst_dout", 32'(dout), 0);
    chk("arst_err", 32'(err_sticky), 0);
    wr_en = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1, 8'h77, 0, 0);
    cyc(0, 0, 1, 0);
    chk("post_rst_dout", 32'(dout), 32'h77);
    repeat (2) @(negedge clk);

    cmp_en = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
